// File: rtl/gray_to_binary_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_to_binary_decoder_if                                                  |
// | Gray-in / binary-out stream bundle with step-error debug signals.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface gray_to_binary_decoder_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] binary_out;
  logic             step_err;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_err;

  modport master (
    output in_valid, gray_in, out_ready, clr_err,
    input  in_ready, out_valid, binary_out, step_err, err_cnt
  );

  modport slave (
    input  in_valid, gray_in, out_ready, clr_err,
    output in_ready, out_valid, binary_out, step_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gray_to_binary_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_to_binary_decoder                                                     |
// | Two-stage valid/ready Gray-to-binary decoder with single-bit step check.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gray_to_binary_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  gray_to_binary_decoder_if.slave      bus
);

  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_gray;
  logic             r_s1_err;
  logic             r_prev_valid;
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_bin;
  logic             r_step_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi_bit;
  logic             w_err;
  logic             w_err_load;
  logic [WIDTH-1:0] w_s1_bin;

  assign w_s2_load  = !r_out_valid || bus.out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign w_in_xfer  = bus.in_valid && w_s1_load;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_diff      = bus.gray_in ^ r_prev_gray;
  assign w_multi_bit = |(w_diff & (w_diff - c_one));
  assign w_err       = r_prev_valid && w_multi_bit;
  assign w_err_load  = w_s2_load && r_s1_valid && r_s1_err;

  always_comb begin
    w_s1_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_s1_bin[i] = ^(r_s1_gray >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_gray    <= '0;
      r_s1_err     <= 1'b0;
      r_prev_valid <= 1'b0;
      r_prev_gray  <= '0;
      r_out_valid  <= 1'b0;
      r_bin        <= '0;
      r_step_err   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_xfer) begin
        r_s1_gray    <= bus.gray_in;
        r_s1_err     <= w_err;
        r_prev_gray  <= bus.gray_in;
        r_prev_valid <= 1'b1;
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_bin      <= w_s1_bin;
          r_step_err <= r_s1_err;
        end
      end
      // A clear that coincides with an error load keeps that error counted.
      if (bus.clr_err) begin
        r_err_cnt <= w_err_load ? c_cnt_one : '0;
      end else if (w_err_load && (r_err_cnt != c_cnt_max)) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end
  end

  assign bus.in_ready   = w_s1_load;
  assign bus.out_valid  = r_out_valid;
  assign bus.binary_out = r_bin;
  assign bus.step_err   = r_step_err;
  assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
